// File: rtl/traffic_light_sequencer.sv
// Main/side-street traffic-light sequencer with an all-red pedestrian walk phase.
// Optional macro TLC_SENSOR_EN: side-street sensor stretches/shortens green phases.
module traffic_light_sequencer #(
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int T_WALK = 3,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Sensor,
    input  logic       WR,
    output logic       WR_Reset,
    output logic [2:0] Main_Light,
    output logic [2:0] Side_Light,
    output logic       Walk_Light
);

    localparam logic [CNT_W-1:0] D_BASE = CNT_W'(T_BASE - 1);
    localparam logic [CNT_W-1:0] D_EXT  = CNT_W'(T_EXT - 1);
    localparam logic [CNT_W-1:0] D_YEL  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] D_WALK = CNT_W'(T_WALK - 1);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [2:0] {
        MG_BASE = 3'd0,
        MG_EXT  = 3'd1,
        MY      = 3'd2,
        WALK    = 3'd3,
        SG_BASE = 3'd4,
`ifdef TLC_SENSOR_EN
        SG_EXT  = 3'd5,
`endif
        SY      = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             wr_clr_nx;
    logic             term;
    logic             sense;

`ifdef TLC_SENSOR_EN
    assign sense = Sensor;
`else
    // Sensor port kept for pin compatibility but has no effect in this build.
    logic unused_sensor;
    assign unused_sensor = Sensor;
    assign sense = 1'b0;
`endif

    // Interval reload value for the state being entered.
    function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
        logic [CNT_W-1:0] d;
        d = D_BASE;
        case (s)
            MG_BASE, SG_BASE: d = D_BASE;
            MG_EXT:           d = D_EXT;
`ifdef TLC_SENSOR_EN
            SG_EXT:           d = D_EXT;
`endif
            MY, SY:           d = D_YEL;
            WALK:             d = D_WALK;
            default:          d = D_BASE;
        endcase
        return d;
    endfunction

    // State, interval counter and walk-clear pulse registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= MG_BASE;
            cnt      <= D_BASE;
            WR_Reset <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            WR_Reset <= wr_clr_nx;
        end
    end

    // Next-state on the terminal tick, counter update and lamp decode.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        wr_clr_nx  = 1'b0;
        Main_Light = RED;
        Side_Light = RED;
        Walk_Light = 1'b0;
        term       = Tick && (cnt == '0);

        case (state)
            MG_BASE: begin
                Main_Light = GRN;
                if (term) state_nx = sense ? MY : MG_EXT;
            end
            MG_EXT: begin
                Main_Light = GRN;
                if (term) state_nx = MY;
            end
            MY: begin
                Main_Light = YEL;
                if (term) begin
                    if (WR) begin
                        state_nx  = WALK;
                        wr_clr_nx = 1'b1;
                    end else begin
                        state_nx  = SG_BASE;
                    end
                end
            end
            WALK: begin
                Walk_Light = 1'b1;
                if (term) state_nx = SG_BASE;
            end
            SG_BASE: begin
                Side_Light = GRN;
`ifdef TLC_SENSOR_EN
                if (term) state_nx = sense ? SG_EXT : SY;
`else
                if (term) state_nx = SY;
`endif
            end
`ifdef TLC_SENSOR_EN
            SG_EXT: begin
                Side_Light = GRN;
                if (term) state_nx = SY;
            end
`endif
            SY: begin
                Side_Light = YEL;
                if (term) state_nx = MG_BASE;
            end
            default: begin
                state_nx = MG_BASE;
            end
        endcase

        // Any state change (including illegal-encoding recovery) reloads.
        if (state_nx != state) begin
            cnt_nx = dur_m1(state_nx);
        end else if (Tick && (cnt != '0)) begin
            cnt_nx = cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Self-checking bench for traffic_light_sequencer: phase-level model plus
// directed scenarios with hand-computed phase lengths.
module tb_traffic_light_sequencer;

    localparam int T_BASE = 6;
    localparam int T_EXT  = 3;
    localparam int T_YEL  = 2;
    localparam int T_WALK = 3;

`ifdef TLC_SENSOR_EN
    localparam bit SEN  = 1'b1;
    localparam int MG_S = 6;
    localparam int SG_S = 9;
`else
    localparam bit SEN  = 1'b0;
    localparam int MG_S = 9;
    localparam int SG_S = 6;
`endif

    localparam logic [2:0] P_MG = 3'd0;
    localparam logic [2:0] P_MY = 3'd1;
    localparam logic [2:0] P_WK = 3'd2;
    localparam logic [2:0] P_SG = 3'd3;
    localparam logic [2:0] P_SY = 3'd4;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Tick = 1'b1;
    logic       Sensor = 1'b0;
    logic       WR = 1'b0;
    logic       WR_Reset;
    logic [2:0] Main_Light;
    logic [2:0] Side_Light;
    logic       Walk_Light;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    traffic_light_sequencer #(
        .T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL),
        .T_WALK(T_WALK), .CNT_W(4)
    ) dut (
        .clk(clk), .Reset(Reset), .Tick(Tick), .Sensor(Sensor),
        .WR(WR), .WR_Reset(WR_Reset), .Main_Light(Main_Light),
        .Side_Light(Side_Light), .Walk_Light(Walk_Light)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Phase-level model: which phase, ticks elapsed, phase length in ticks.
    typedef struct packed {
        logic [2:0] ph;
        logic [7:0] e;
        logic [7:0] len;
        logic       wrr;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(input mdl_t s, input logic rst,
                                   input logic tk, input logic sn,
                                   input logic wr);
        mdl_t n;
        n = s;
        n.wrr = 1'b0;
        if (rst) begin
            n.ph = P_MG; n.e = 8'd0; n.len = 8'(T_BASE);
            return n;
        end
        if (!tk) return n;
        n.e = s.e + 8'd1;
        if (s.ph == P_MG && n.e == 8'(T_BASE) && !(SEN && sn))
            n.len = 8'(T_BASE + T_EXT);
        if (s.ph == P_SG && n.e == 8'(T_BASE) && (SEN && sn))
            n.len = 8'(T_BASE + T_EXT);
        if (n.e == n.len) begin
            n.e = 8'd0;
            case (s.ph)
                P_MG: begin n.ph = P_MY; n.len = 8'(T_YEL); end
                P_MY: begin
                    if (wr) begin
                        n.ph = P_WK; n.len = 8'(T_WALK); n.wrr = 1'b1;
                    end else begin
                        n.ph = P_SG; n.len = 8'(T_BASE);
                    end
                end
                P_WK: begin n.ph = P_SG; n.len = 8'(T_BASE); end
                P_SG: begin n.ph = P_SY; n.len = 8'(T_YEL); end
                default: begin n.ph = P_MG; n.len = 8'(T_BASE); end
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) m <= mstep(m, Reset, Tick, Sensor, WR);

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            case (m.ph)
                P_MG: begin chk("main", int'(Main_Light), 1); chk("side", int'(Side_Light), 4); end
                P_MY: begin chk("main", int'(Main_Light), 2); chk("side", int'(Side_Light), 4); end
                P_WK: begin chk("main", int'(Main_Light), 4); chk("side", int'(Side_Light), 4); end
                P_SG: begin chk("main", int'(Main_Light), 4); chk("side", int'(Side_Light), 1); end
                default: begin chk("main", int'(Main_Light), 4); chk("side", int'(Side_Light), 2); end
            endcase
            chk("walk", int'(Walk_Light), (m.ph == P_WK) ? 1 : 0);
            chk("wr_reset", int'(WR_Reset), int'(m.wrr));
        end
    end

    // Length in cycles of the next run of a lamp pattern.
    task automatic run_len(input logic [2:0] mm, input logic [2:0] ss,
                           input bit fresh, input int exp, input string nm);
        int n;
        int len;
        n = 0;
        len = 0;
        if (fresh)
            while (Main_Light == mm && Side_Light == ss && n < 100) begin
                @(negedge clk); n++;
            end
        n = 0;
        while (!(Main_Light == mm && Side_Light == ss) && n < 100) begin
            @(negedge clk); n++;
        end
        while (Main_Light == mm && Side_Light == ss && len < 100) begin
            len++; @(negedge clk);
        end
        chk(nm, len, exp);
    endtask

    initial begin
        int n;
        int wk;
        int pulses;
        int run;
        int my_len;
        bit in_my;
        bit started;

        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_main", int'(Main_Light), 1);
        chk("rst_side", int'(Side_Light), 4);
        chk("rst_walk", int'(Walk_Light), 0);
        chk("rst_wrr", int'(WR_Reset), 0);
        @(negedge clk);
        Reset = 1'b0;

        // Sensor low, continuous tick.
        run_len(3'b001, 3'b100, 1'b1, 9, "mg_nosens");
        run_len(3'b010, 3'b100, 1'b0, 2, "my_nosens");
        run_len(3'b100, 3'b001, 1'b0, 6, "sg_nosens");
        run_len(3'b100, 3'b010, 1'b0, 2, "sy_nosens");

        // Sensor high.
        Sensor = 1'b1;
        run_len(3'b001, 3'b100, 1'b1, MG_S, "mg_sens");
        run_len(3'b010, 3'b100, 1'b0, 2, "my_sens");
        run_len(3'b100, 3'b001, 1'b0, SG_S, "sg_sens");
        run_len(3'b100, 3'b010, 1'b0, 2, "sy_sens");
        Sensor = 1'b0;

        // Walk request served once, cleared on the pulse.
        repeat (3) @(negedge clk);
        WR = 1'b1;
        n = 0;
        while (!WR_Reset && n < 60) begin @(negedge clk); n++; end
        chk("wrr_seen", int'(WR_Reset), 1);
        chk("walk_on_pulse", int'(Walk_Light), 1);
        WR = 1'b0;
        run_len(3'b100, 3'b100, 1'b0, 3, "walk_len");
        wk = 0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (Walk_Light) wk++;
            if (WR_Reset) pulses++;
            @(negedge clk);
        end
        chk("no_second_walk", wk, 0);
        chk("no_second_pulse", pulses, 0);

        // Sparse tick, sensor wiggling between ticks.
        my_len = 0;
        run = 0;
        in_my = 1'b0;
        started = 1'b0;
        for (int c = 0; c < 120; c++) begin
            Tick = (c % 4 == 0);
            Sensor = ((c / 4) % 3 == 0) ^ (c % 4 != 0);
            @(negedge clk);
            if (Main_Light == 3'b010) begin
                if (!in_my) begin run = 0; started = (c > 0); end
                in_my = 1'b1;
                run++;
            end else begin
                if (in_my && started) my_len = run;
                in_my = 1'b0;
            end
        end
        chk("my_sparse_tick", my_len, 8);
        Tick = 1'b1;

        // Reset in the middle of side green.
        Sensor = 1'b1;
        run_len(3'b100, 3'b001, 1'b1, SG_S, "sg_before_rst");
        n = 0;
        while (!(Side_Light == 3'b001) && n < 60) begin @(negedge clk); n++; end
        repeat (SG_S - 2) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_main", int'(Main_Light), 1);
        chk("mid_rst_side", int'(Side_Light), 4);
        chk("mid_rst_walk", int'(Walk_Light), 0);
        chk("mid_rst_wrr", int'(WR_Reset), 0);
        Reset = 1'b0;
        run_len(3'b001, 3'b100, 1'b0, MG_S, "mg_after_rst");

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

- Main/side-street traffic-light state machine that also serves pedestrian walk requests.
- Counts intervals on a one-cycle `Tick` enable (nominally 1 Hz, from the prescaler).
- Samples the side-street `Sensor` to stretch or shorten green phases.
- Consumes the latched walk request `WR` from `WalkRegister`, inserting an all-red walk phase. It clears the request through `WR_Reset`.
- Sits between `WalkRegister`/sensor conditioning and the lamp drivers.

## Interface
- `T_BASE`, 6: base green duration, in ticks (≥1)
- `T_EXT`, 3: green extension, in ticks (≥1)
- `T_YEL`, 2: yellow duration, in ticks (≥1)
- `T_WALK`, 3: walk (all-red) duration, in ticks (≥1)
- `CNT_W`, 4: interval counter width; must hold max(T_*)−1
- `clk` input 1: system clock, rising edge
- `Reset` input 1: synchronous, active-high
- `Tick` input 1: one-cycle interval enable
- `Sensor` input 1: side-street vehicle present (pre-synchronised level)
- `WR` input 1: latched walk request from `WalkRegister`
- `WR_Reset` output 1: one-cycle clear pulse to `WalkRegister`
- `Main_Light` output 3: main-street lamps, {R,Y,G} = bits [2:0]
- `Side_Light` output 3: side-street lamps, {R,Y,G}
- `Walk_Light` output 1: pedestrian walk lamp

## Operation
- States: `MG_BASE`, `MG_EXT`, `MY`, `WALK`, `SG_BASE`, `SG_EXT`, `SY`.
- Lamp outputs per state:
  - MG_*: Main=3'b001, Side=3'b100.
  - MY: Main=3'b010, Side=3'b100.
  - WALK: Main=Side=3'b100, Walk_Light=1.
  - SG_*: Main=3'b100, Side=3'b001.
  - SY: Main=3'b100, Side=3'b010.
  - Walk_Light is 0 in every state except WALK.
- Interval counter:
  - On state entry it loads duration−1.
  - It decrements on each `Tick`.
  - A state is exited on the `Tick` seen while the counter is 0, so every state lasts exactly its duration in ticks.
- Transitions, evaluated only on that terminal `Tick`:
  - MG_BASE → MY if Sensor=1, else MG_EXT.
  - MG_EXT → MY.
  - MY → WALK if WR=1, else SG_BASE.
  - WALK → SG_BASE.
  - SG_BASE → SG_EXT if Sensor=1, else SY.
  - SG_EXT → SY.
  - SY → MG_BASE.
- Sensor and WR are sampled only at the terminal tick of the state that tests them. Values between ticks are ignored.
- WR_Reset:
  - Registered, high for exactly one clk cycle.
  - Asserted on the cycle after the MY→WALK transition edge, i.e. the first cycle in WALK.
- A request latched during WALK (after the clear pulse) is held by `WalkRegister` and served at the next MY exit.
- Illegal state encodings recover to MG_BASE on the next clk, with the counter reloaded with T_BASE−1.

## Timing
- Reset values:
  - State is MG_BASE, counter is T_BASE−1.
  - Main_Light=3'b001, Side_Light=3'b100, Walk_Light=0, WR_Reset=0.
- Reset takes priority over Tick in the same cycle. Reset mid-phase aborts the phase immediately; an outstanding WR stays latched externally.
- All outputs are decoded from registered state. Lamps change on the clk edge after the terminal Tick cycle, a latency of 1 cycle.
- With Tick held high continuously, each state lasts exactly duration clk cycles. This is the simulation mode.
- Phase lengths:
  - Main green = T_BASE + (Sensor ? 0 : T_EXT) ticks.
  - Side green = T_BASE + (Sensor ? T_EXT : 0) ticks.

## Configuration
- `TLC_SENSOR_EN` defined: Sensor behaves as described above.
- `TLC_SENSOR_EN` undefined:
  - The Sensor port remains but is ignored.
  - MG_BASE always → MG_EXT, and SG_BASE always → SY.
  - The SG_EXT state is not compiled.

## Test plan
- Reset, Tick=1 every cycle, Sensor=0, WR=0 → cycle MG 9, MY 2, SG 6, SY 2 cycles (period 19); Walk_Light and WR_Reset never high.
- Sensor=1 held, WR=0 → MG 6, MY 2, SG 9, SY 2 cycles; period still 19.
- WR=1 from cycle 3 until WR_Reset seen → after MY, WALK for 3 cycles with Main=Side=3'b100 and Walk_Light=1; WR_Reset high exactly the first WALK cycle; bench clears WR → next round has no WALK.
- Tick pulsed every 4th cycle, Sensor toggling between ticks → transitions only on Tick cycles; decisions follow Sensor's value at the terminal tick only; MY spans 8 clk cycles.
- Reset asserted mid-SG_EXT with Tick=1 → next cycle outputs Main=3'b001, Side=3'b100, Walk_Light=0, WR_Reset=0; MG_BASE lasts full 6 ticks.
- Build without `TLC_SENSOR_EN`, Sensor=1 → MG 9, SG 6 ticks (sensor ignored).
